div_nbit_seq: RTL and testbench
===============================

# div_nbit_seq

Sequential unsigned divider and the inverse of the FIR datapath's array multiplier. It takes a 2·DATA_WIDTH dividend, such as a product word, and a DATA_WIDTH divisor. It returns a DATA_WIDTH quotient and remainder using one restoring-division step per clock. The block sits beside the multiplier in the FIR datapath for gain normalisation and for round-trip checking of products.

## Interface
- DATA_WIDTH, default from FirPkg, operand width W; all widths below derive from it.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- start_i  input  1  request; accepted only on an edge where busy_o=0.
- N  input  2W  dividend; sampled on the accepting edge.
- D  input  W  divisor; sampled on the accepting edge.
- Q  output  W  quotient; registered; held until the next accepted start.
- R  output  W  remainder; registered; held until the next accepted start.
- valid_o  output  1  one-cycle pulse marking Q/R/dz_o/ovf_o as new.
- busy_o  output  1  high while in state CALC.
- dz_o  output  1  divide-by-zero flag for the current result.
- ovf_o  output  1  quotient-overflow flag for the current result (N[2W-1:W] ≥ D, D≠0).

## Operation
- States:
  - IDLE: wait for start_i.
  - CALC: iterate; busy_o=1.
  - DONE: one cycle; valid_o=1.
- IDLE/DONE with start_i=1 and D=0 → DONE.
  - dz_o=1, ovf_o=0.
  - Q = all ones, R = N[W-1:0].
- IDLE/DONE with start_i=1, D≠0 and N[2W-1:W] ≥ D → DONE.
  - ovf_o=1, dz_o=0.
  - Q = all ones, R = 0.
- IDLE/DONE with start_i=1, otherwise → CALC.
  - Partial remainder rem (W bits) loaded with N[2W-1:W].
  - Shift register loaded with N[W-1:0]; step counter cleared.
- CALC, each edge (W steps, MSB-first):
  - Form t = {rem, next dividend bit} (W+1 bits).
  - If t ≥ D: rem = t − D, quotient bit = 1.
  - Else: rem = t[W-1:0], quotient bit = 0.
  - If t[W]=1 the subtraction always succeeds.
  - Trial subtraction uses one addsub_nbit instance with add_sub=1'b1; its carry_o is combined with t[W] to decide the step.
- CALC after the W-th step → DONE: Q/R registered, dz_o=ovf_o=0.
- DONE with no start_i → IDLE.
- start_i while busy_o=1 is ignored: no queueing, no effect on the result in progress.
- All arithmetic is unsigned. When dz_o=ovf_o=0: N = Q·D + R and R < D.

## Timing
- Reset values:
  - State IDLE.
  - Q=0, R=0.
  - valid_o=0, busy_o=0, dz_o=0, ovf_o=0.
  - Internal rem, shift register and counter are 0.
- Reset asserted mid-CALC: immediate return to the reset values; the abandoned result never produces valid_o.
- Accepting edge k, normal path:
  - busy_o high after edges k..k+W-1.
  - valid_o high for exactly the cycle after edge k+W.
  - Latency W cycles.
- Accepting edge k, dz/ovf path: valid_o high in the cycle after edge k; busy_o stays 0.
- Back-to-back: start_i high during the DONE cycle is accepted on the following edge. Throughput is one division per W+1 cycles.
- Outputs only change on an edge producing valid_o, or on reset.

## Test plan
- N=100, D=7, single start pulse:
  - Q=14, R=2, dz_o=ovf_o=0.
  - valid_o exactly W cycles after the accepting edge; busy_o high W cycles.
- N=(2^W−1)·(2^W−1)+(2^W−2), D=2^W−1 (largest multiplier product plus remainder):
  - Q=2^W−1, R=2^W−2, no flags.
  - Randomised N=A·B+r (r<B) round-trips to Q=A, R=r.
- D=0, N=1234:
  - dz_o=1, Q=all ones, R=1234 mod 2^W.
  - valid_o in the cycle after the accepting edge.
- N={5, W'b0}, D=5:
  - ovf_o=1, dz_o=0, Q=all ones, R=0; one-cycle latency.
- Start N=100, D=7; at step 3, pulse start_i with N=50, D=5:
  - Second request ignored; result Q=14, R=2.
  - Then start_i in the DONE cycle with N=50, D=5 → Q=10, R=0, W cycles later.
- Start N=100, D=7; drop rst_ni at step W/2:
  - All outputs 0 immediately; no valid_o.
  - After release, N=9, D=3 → Q=3, R=0.

Source files
------------

// File: rtl/div_nbit_seq_if.sv
// Request/result bundle for the sequential divider.
// The requester drives start_i/N/D; the divider returns Q/R and its status flags.
interface div_nbit_seq_if #(
   parameter int DATA_WIDTH = 8
);
   logic                      start_i;
   logic [2*DATA_WIDTH-1:0]   N;
   logic [DATA_WIDTH-1:0]     D;
   logic [DATA_WIDTH-1:0]     Q;
   logic [DATA_WIDTH-1:0]     R;
   logic                      valid_o;
   logic                      busy_o;
   logic                      dz_o;
   logic                      ovf_o;

   modport master (
      output start_i, N, D,
      input  Q, R, valid_o, busy_o, dz_o, ovf_o
   );

   modport slave (
      input  start_i, N, D,
      output Q, R, valid_o, busy_o, dz_o, ovf_o
   );
endinterface

// File: rtl/div_nbit_seq.sv
// Restoring unsigned divider: a 2W-bit dividend over a W-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are resolved on the accepting edge without iterating.
//
// state | meaning
// IDLE  | waiting for start_i
// CALC  | iterating one restoring step per edge, busy_o=1
// DONE  | single cycle, valid_o=1, a new start_i may be accepted

module addsub_nbit #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             add_sub,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
);
   logic [WIDTH-1:0] b_eff;

   assign b_eff = b_i ^ {WIDTH{add_sub}};
   assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_sub};
endmodule

module div_nbit_seq #(
   parameter int DATA_WIDTH = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   div_nbit_seq_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [W-1:0]   rem_q;
   logic [W-1:0]   sreg_q;
   logic [W-1:0]   d_q;
   logic [CW-1:0]  cnt_q;

   logic           accept;
   logic           is_zero;
   logic           is_ovf;
   logic           last_step;
   logic [W:0]     t;
   logic [W-1:0]   diff;
   logic           no_borrow;
   logic           take;
   logic [W-1:0]   q_next;
   logic [W-1:0]   rem_next;

   assign is_zero   = (bus.D == '0);
   assign is_ovf    = !is_zero && (bus.N[2*W-1:W] >= bus.D);
   assign last_step = (cnt_q == CW'(W - 1));

   // The dividend shift register fills with quotient bits from the LSB as dividend bits leave the MSB.
   assign t = {rem_q, sreg_q[W-1]};

   addsub_nbit #(.WIDTH(W)) u_sub (
      .a_i     (t[W-1:0]),
      .b_i     (d_q),
      .add_sub (1'b1),
      .sum_o   (diff),
      .carry_o (no_borrow)
   );

   // With t[W] set, t exceeds D and the low W bits of the difference are still exact since rem < D.
   assign take     = t[W] | no_borrow;
   assign rem_next = take ? diff : t[W-1:0];
   assign q_next   = {sreg_q[W-2:0], take};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start_i) begin
               accept  = 1'b1;
               state_d = (is_zero || is_ovf) ? DONE : CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (last_step) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy_o  = (state_q == CALC);
   assign bus.valid_o = (state_q == DONE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem_q     <= '0;
         sreg_q    <= '0;
         d_q       <= '0;
         cnt_q     <= '0;
         bus.Q     <= '0;
         bus.R     <= '0;
         bus.dz_o  <= 1'b0;
         bus.ovf_o <= 1'b0;
      end else if (accept) begin
         if (is_zero) begin
            bus.Q     <= '1;
            bus.R     <= bus.N[W-1:0];
            bus.dz_o  <= 1'b1;
            bus.ovf_o <= 1'b0;
         end else if (is_ovf) begin
            bus.Q     <= '1;
            bus.R     <= '0;
            bus.dz_o  <= 1'b0;
            bus.ovf_o <= 1'b1;
         end else begin
            rem_q  <= bus.N[2*W-1:W];
            sreg_q <= bus.N[W-1:0];
            d_q    <= bus.D;
            cnt_q  <= '0;
         end
      end else if (state_q == CALC) begin
         rem_q  <= rem_next;
         sreg_q <= q_next;
         cnt_q  <= cnt_q + CW'(1);
         if (last_step) begin
            bus.Q     <= q_next;
            bus.R     <= rem_next;
            bus.dz_o  <= 1'b0;
            bus.ovf_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_div_nbit_seq.sv
// Self-checking bench for div_nbit_seq: directed literal cases, round-trip products and
// random traffic, all checked each cycle against an arithmetic reference of the divider.
module tb_div_nbit_seq;
   localparam int W    = 8;
   localparam int NW   = 2 * W;
   localparam int MAXV = (1 << W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   div_nbit_seq_if #(.DATA_WIDTH(W)) bus ();

   div_nbit_seq #(.DATA_WIDTH(W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: what a divider must return for one request, straight from the arithmetic.
   function automatic void ref_div(input int n, input int d, output int q, output int r,
                                   output bit dz, output bit ovf);
      dz  = 0;
      ovf = 0;
      if (d == 0) begin
         q  = MAXV;
         r  = n % (1 << W);
         dz = 1;
      end else if ((n >> W) >= d) begin
         q   = MAXV;
         r   = 0;
         ovf = 1;
      end else begin
         q = n / d;
         r = n % d;
      end
   endfunction

   // Timeline model: a normal request occupies W edges, flagged requests answer at once.
   int         busy_left = 0;
   logic       exp_valid = 1'b0;
   logic       exp_dz    = 1'b0;
   logic       exp_ovf   = 1'b0;
   int         exp_q     = 0;
   int         exp_r     = 0;
   int         pend_q    = 0;
   int         pend_r    = 0;
   int         m_q, m_r;
   bit         m_dz, m_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_left = 0;
         exp_valid = 1'b0;
         exp_q     = 0;
         exp_r     = 0;
         exp_dz    = 1'b0;
         exp_ovf   = 1'b0;
      end else begin
         exp_valid = 1'b0;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               exp_valid = 1'b1;
               exp_q     = pend_q;
               exp_r     = pend_r;
               exp_dz    = 1'b0;
               exp_ovf   = 1'b0;
            end
         end else if (bus.start_i === 1'b1) begin
            ref_div(int'(bus.N), int'(bus.D), m_q, m_r, m_dz, m_ovf);
            if (m_dz || m_ovf) begin
               exp_valid = 1'b1;
               exp_q     = m_q;
               exp_r     = m_r;
               exp_dz    = m_dz;
               exp_ovf   = m_ovf;
            end else begin
               busy_left = W;
               pend_q    = m_q;
               pend_r    = m_r;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("valid_o", 32'(bus.valid_o), 32'(exp_valid));
      chk("busy_o", 32'(bus.busy_o), 32'(busy_left > 0));
      chk("Q", 32'(bus.Q), 32'(exp_q));
      chk("R", 32'(bus.R), 32'(exp_r));
      chk("dz_o", 32'(bus.dz_o), 32'(exp_dz));
      chk("ovf_o", 32'(bus.ovf_o), 32'(exp_ovf));
   end

   task automatic issue(input int n, input int d);
      @(posedge clk); #1;
      bus.start_i = 1'b1;
      bus.N       = NW'(n);
      bus.D       = W'(d);
      @(posedge clk); #1;
      bus.start_i = 1'b0;
   endtask

   // Counts edges after the accepting edge until valid_o shows, plus cycles spent busy.
   task automatic collect(input string tag, input int eq, input int er, input int edz,
                          input int eovf, input int elat);
      int lat   = 0;
      int nbusy = 0;
      bit seen  = 0;
      for (int i = 0; i < 3 * W && !seen; i++) begin
         @(negedge clk);
         if (bus.busy_o) nbusy++;
         if (bus.valid_o) seen = 1;
         else lat++;
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, "_q"}, 32'(bus.Q), 32'(eq));
         chk({tag, "_r"}, 32'(bus.R), 32'(er));
         chk({tag, "_dz"}, 32'(bus.dz_o), 32'(edz));
         chk({tag, "_ovf"}, 32'(bus.ovf_o), 32'(eovf));
         chk({tag, "_lat"}, 32'(lat), 32'(elat));
         chk({tag, "_busy"}, 32'(nbusy), 32'(elat));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, b, r;
      bus.start_i = 1'b0;
      bus.N       = '0;
      bus.D       = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_q", 32'(bus.Q), 32'd0);
      chk("rst_r", 32'(bus.R), 32'd0);
      chk("rst_valid", 32'(bus.valid_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      rst_n = 1'b1;

      issue(100, 7);
      collect("basic", 14, 2, 0, 0, W);

      issue(MAXV * MAXV + (MAXV - 1), MAXV);
      collect("maxprod", MAXV, MAXV - 1, 0, 0, W);

      issue(1234, 0);
      collect("divzero", MAXV, 1234 % 256, 1, 0, 0);

      issue(5 << W, 5);
      collect("ovf", MAXV, 0, 0, 1, 0);

      // Start ignored mid-flight, then back-to-back start in the DONE cycle.
      issue(100, 7);
      repeat (2) @(posedge clk);
      #1;
      bus.start_i = 1'b1;
      bus.N       = NW'(50);
      bus.D       = W'(5);
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      collect("ignored", 14, 2, 0, 0, W - 3);
      bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      collect("b2b", 10, 0, 0, 0, W);

      // Reset in the middle of an iteration.
      issue(100, 7);
      repeat (W / 2 - 1) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_q", 32'(bus.Q), 32'd0);
      chk("midrst_r", 32'(bus.R), 32'd0);
      chk("midrst_valid", 32'(bus.valid_o), 32'd0);
      chk("midrst_busy", 32'(bus.busy_o), 32'd0);
      chk("midrst_dz", 32'(bus.dz_o), 32'd0);
      chk("midrst_ovf", 32'(bus.ovf_o), 32'd0);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (W + 2) @(posedge clk);
      issue(9, 3);
      collect("postrst", 3, 0, 0, 0, W);

      // Round trip of products plus a remainder.
      for (int i = 0; i < 20; i++) begin
         a = int'($urandom_range(0, MAXV));
         b = int'($urandom_range(1, MAXV));
         r = int'($urandom_range(0, b - 1));
         issue(a * b + r, b);
         collect("roundtrip", a, r, 0, 0, W);
      end

      // Free-running random traffic, including starts while busy.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         bus.start_i = ($urandom_range(0, 2) == 0);
         bus.N       = NW'($urandom);
         case ($urandom_range(0, 7))
            0:       bus.D = '0;
            1, 2:    bus.D = W'($urandom_range(1, 15));
            default: bus.D = W'($urandom);
         endcase
      end
      bus.start_i = 1'b0;
      repeat (W + 3) @(posedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
